// File: rtl/reg_file_pkg.sv
// Shared constants and bus-slicing helper for the register-file write arbiter.
package reg_file_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int REG_DATA_W   = 32;
  localparam int REG_WR_PORTS = 4;

  localparam int SLICE_BUS_W  = 2048;
  localparam int SLICE_MAX_W  = 64;

  // Callers zero-extend the packed bus to SLICE_BUS_W and truncate the result to their width.
  function automatic logic [SLICE_MAX_W-1:0] bus_slice(input logic [SLICE_BUS_W-1:0] bus,
                                                       input int unsigned idx,
                                                       input int unsigned width);
    logic [SLICE_BUS_W-1:0] shifted;
    shifted = bus >> (idx * width);
    return shifted[SLICE_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/reg_file_wr_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer, searching upward modulo N.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [N-1:0]     req,
  input  logic             enable,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic             found;
  int unsigned      cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    if (enable) begin
      for (int unsigned off = 0; off < N; off++) begin
        cand = (32'(ptr) + off) % N;
        if (!found && req[cand[IDX_W-1:0]]) begin
          found                     = 1'b1;
          grant[cand[IDX_W-1:0]]    = 1'b1;
          grant_idx                 = cand[IDX_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_wr_arbiter.sv
// Round-robin arbiter sharing the reg_file write port among N requesters, with registered outputs.
// REG_FILE_ZERO_PROTECT_EN: handshakes to address 0 are acked but never raise wr_en.
module reg_file_wr_arbiter
  import reg_file_pkg::*;
#(
  parameter int W = REG_ADDR_W,
  parameter int B = REG_DATA_W,
  parameter int N = REG_WR_PORTS
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         hold,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_addr,
  input  logic [N*B-1:0] req_data,
  output logic [N-1:0]   ack,
  output logic           wr_en,
  output logic [W-1:0]   w_addr,
  output logic [B-1:0]   w_data
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             enable;
  logic             hs;
  logic [W-1:0]     sel_addr;
  logic [B-1:0]     sel_data;
  logic             wr_ok;

  logic             vld_p1;
  logic [W-1:0]     addr_p1;
  logic [B-1:0]     data_p1;

  assign enable = n_reset & ~hold;

  rr_arbiter #(.N(N)) u_rr_arbiter (
    .clk       (clk),
    .n_reset   (n_reset),
    .req       (req),
    .enable    (enable),
    .advance   (hs),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign ack = grant;
  assign hs  = |grant;

  // Stage 0: select the granted requester's address and data.
  assign sel_addr = W'(bus_slice(SLICE_BUS_W'(req_addr), 32'(grant_idx), W));
  assign sel_data = B'(bus_slice(SLICE_BUS_W'(req_data), 32'(grant_idx), B));

`ifdef REG_FILE_ZERO_PROTECT_EN
  assign wr_ok = (sel_addr != '0);
`else
  assign wr_ok = 1'b1;
`endif

  // Stage 1: registered write port; idle cycles return everything to zero.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else if (hs) begin
      vld_p1  <= wr_ok;
      addr_p1 <= sel_addr;
      data_p1 <= sel_data;
    end else begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end
  end

  assign wr_en  = vld_p1;
  assign w_addr = addr_p1;
  assign w_data = data_p1;

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// Directed table-driven bench for reg_file_wr_arbiter with a behavioural register-file model.
module tb_reg_file_wr_arbiter;

  localparam int W = 5;
  localparam int B = 32;
  localparam int N = 4;
`ifdef REG_FILE_ZERO_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic           clk;
  logic           n_reset;
  logic           hold;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_addr;
  logic [N*B-1:0] req_data;
  logic [N-1:0]   ack;
  logic           wr_en;
  logic [W-1:0]   w_addr;
  logic [B-1:0]   w_data;

  logic [B-1:0] mem [2**W];

  int n_vec;
  int n_bad;

  typedef struct {
    logic           hold;
    logic [N-1:0]   req;
    logic [N*W-1:0] addr;
    logic [N*B-1:0] data;
    logic [N-1:0]   exp_ack;
    logic           exp_wr;
    logic [W-1:0]   exp_addr;
    logic [B-1:0]   exp_data;
  } vec_t;

  vec_t vecs [$];

  reg_file_wr_arbiter #(.W(W), .B(B), .N(N)) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .hold     (hold),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .ack      (ack),
    .wr_en    (wr_en),
    .w_addr   (w_addr),
    .w_data   (w_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_en) mem[w_addr] <= w_data;
  end

  task automatic chk(input string name, input logic [B-1:0] act, input logic [B-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pa(input int a0, input int a1, input int a2, input int a3);
    return {W'(a3), W'(a2), W'(a1), W'(a0)};
  endfunction

  function automatic logic [N*B-1:0] pd(input int d0, input int d1, input int d2, input int d3);
    return {B'(d3), B'(d2), B'(d1), B'(d0)};
  endfunction

  function automatic vec_t mk(input logic h, input logic [N-1:0] r, input logic [N*W-1:0] a,
                              input logic [N*B-1:0] d, input logic [N-1:0] ea, input logic ew,
                              input int eaddr, input int edata);
    vec_t v;
    v.hold = h; v.req = r; v.addr = a; v.data = d; v.exp_ack = ea;
    v.exp_wr = ew; v.exp_addr = W'(eaddr); v.exp_data = B'(edata);
    return v;
  endfunction

  initial begin
    logic [N*W-1:0] da;
    logic [N*B-1:0] dd;
    n_vec = 0;
    n_bad = 0;
    for (int i = 0; i < 2**W; i++) mem[i] = '0;
    da = pa(1, 2, 3, 4);
    dd = pd(10, 20, 30, 40);

    // single requester 2 from pointer 0
    vecs.push_back(mk(0, 4'b0100, pa(1, 2, 20, 4), pd(10, 20, 100, 40), 4'b0100, 1, 20, 100));
    vecs.push_back(mk(0, 4'b0000, da, dd, 4'b0000, 0, 0, 0));
    // requester 3 alone brings the pointer back to 0
    vecs.push_back(mk(0, 4'b1000, da, dd, 4'b1000, 1, 4, 40));
    // all four requesting: strict rotation, continuous writes
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 4'b1111, da, dd, 4'(1 << (i % 4)), 1, (i % 4) + 1, 10 * ((i % 4) + 1)));
    // pointer to 2, then requests below it wrap around
    vecs.push_back(mk(0, 4'b0010, da, dd, 4'b0010, 1, 2, 20));
    vecs.push_back(mk(0, 4'b0011, da, dd, 4'b0001, 1, 1, 10));
    vecs.push_back(mk(0, 4'b0011, da, dd, 4'b0010, 1, 2, 20));
    // hold blocks grants
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 4'b0010, da, dd, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0010, da, dd, 4'b0010, 1, 2, 20));
    vecs.push_back(mk(0, 4'b0000, da, dd, 4'b0000, 0, 0, 0));
    // write to address 0
    vecs.push_back(mk(0, 4'b0001, pa(0, 2, 3, 4), dd, 4'b0001, !PROT, 0, 10));
    vecs.push_back(mk(0, 4'b0000, da, dd, 4'b0000, 0, 0, 0));

    clk = 1'b0;
    n_reset = 1'b0;
    hold = 1'b0;
    req = 4'b1111;
    req_addr = da;
    req_data = dd;

    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("reset_ack", B'(ack), 0);
      @(posedge clk); #1;
      chk("reset_wr_en", B'(wr_en), 0);
      chk("reset_w_addr", B'(w_addr), 0);
      chk("reset_w_data", w_data, 0);
    end

    @(negedge clk);
    n_reset = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      hold = vecs[i].hold;
      req = vecs[i].req;
      req_addr = vecs[i].addr;
      req_data = vecs[i].data;
      #1;
      chk($sformatf("v%0d_ack", i), B'(ack), B'(vecs[i].exp_ack));
      @(posedge clk); #1;
      chk($sformatf("v%0d_wr_en", i), B'(wr_en), B'(vecs[i].exp_wr));
      chk($sformatf("v%0d_w_addr", i), B'(w_addr), B'(vecs[i].exp_addr));
      chk($sformatf("v%0d_w_data", i), w_data, vecs[i].exp_data);
    end

    chk("mem20", mem[20], 100);
    chk("mem0", mem[0], PROT ? 0 : 10);
    chk("mem4", mem[4], 40);

    // reset with a pending request: no grant, no write, pointer cleared
    @(negedge clk);
    n_reset = 1'b0;
    hold = 1'b0;
    req = 4'b0010;
    req_addr = da;
    req_data = dd;
    #1;
    chk("rst_mid_ack", B'(ack), 0);
    @(posedge clk); #1;
    chk("rst_mid_wr_en", B'(wr_en), 0);
    @(negedge clk);
    n_reset = 1'b1;
    req = 4'b1111;
    #1;
    chk("ptr_after_rst", B'(ack), 4'b0001);
    @(posedge clk); #1;
    chk("ptr_after_rst_w_addr", B'(w_addr), 1);
    // hold mid-stream: grants stop immediately, the registered write still shows
    @(negedge clk);
    hold = 1'b1;
    #1;
    chk("hold_mid_ack", B'(ack), 0);
    chk("hold_mid_wr_en", B'(wr_en), 1);
    @(posedge clk); #1;
    chk("hold_mid_wr_after", B'(wr_en), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file_wr_arbiter.md
Name: reg_file_wr_arbiter

Overview:
- Shares the single write port of the 2-read/1-write register file (reg_file) between N independent requesters using round-robin arbitration.
- Each requester presents an address and data with a req/ack handshake. The arbiter drives the register file's wr_en, w_addr and w_data from registered outputs.
- Sits directly in front of reg_file. The read ports are untouched.

Parameters:
- W, 5, address width; the register file has 2^W entries.
- B, 32, data width.
- N, 4, number of write requesters (N >= 2).

Ports:
- clk  input  1  system clock, rising edge.
- n_reset  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- hold  input  1  when 1, no grants are issued (ack all 0); pending requests wait.
- req  input  N  req[i] = requester i has a valid write.
- req_addr  input  N*W  packed addresses; slice i is [i*W +: W].
- req_data  input  N*B  packed data; slice i is [i*B +: B].
- ack  output  N  one-hot-or-zero grant, combinational; handshake when req[i] && ack[i] at a rising edge.
- wr_en  output  1  to reg_file wr_en.
- w_addr  output  W  to reg_file w_addr.
- w_data  output  B  to reg_file w_data.

Behaviour:
- Reset (n_reset=0 at an edge):
  - wr_en=0, w_addr=0, w_data=0, rr pointer=0.
  - ack is forced to all 0 while n_reset=0, so no handshake can complete in a reset cycle.
  - A request accepted in the cycle before reset still produces its wr_en cycle only if reset is deasserted at that edge; otherwise it is discarded.
- Arbitration (combinational):
  - Among the asserted req bits, grant the first index at or after rr pointer, searching upward modulo N.
  - ack = 0 if hold=1, n_reset=0 or req=0.
  - At most one ack bit is ever high.
- Pointer update: on a handshake by requester g, rr pointer <= (g+1) mod N. With no handshake the pointer is unchanged.
- Latency: a handshake at edge k gives wr_en=1, w_addr=req_addr[g], w_data=req_data[g] during cycle k..k+1. reg_file writes the data at edge k+1.
- Throughput: one write per cycle. Back-to-back handshakes give continuous wr_en.
- Idle outputs: in a cycle with no handshake at the preceding edge, wr_en=0 and w_addr/w_data return to 0.
- Requester rules:
  - req, addr and data must stay stable until ack is seen.
  - The requester may drop req, or present a new transaction, in the cycle after its handshake.
  - Holding req high after ack means a new, separate write.
- Fairness: with all N requesting continuously, each is granted exactly once every N cycles.
- Simultaneous requests to the same address: serialised in grant order; the last granted wins in reg_file.
- hold asserted mid-stream: grants stop from the same cycle. An already-registered wr_en still completes.

Optional Feature:
- Macro: REG_FILE_ZERO_PROTECT_EN.
- Defined: a handshake with address 0 is acked and advances the pointer normally, but wr_en stays 0 for that cycle, so register 0 stays hard-wired zero.
- Undefined: address 0 is written like any other address.

Decomposition:
- Package reg_file_pkg holds:
  - default constants REG_ADDR_W=5, REG_DATA_W=32, REG_WR_PORTS=4;
  - a function that extracts slice i from a packed address or data bus.
- One sub-module, rr_arbiter:
  - inputs: N-bit req, enable, advance, clk, n_reset;
  - outputs: one-hot grant and grant index;
  - owns the pointer.
- reg_file_wr_arbiter adds the datapath mux, the output registers and the optional macro.

Test Plan:
- Reset then idle: hold n_reset=0 for 2 cycles with req=4'b1111 -> ack=0, wr_en=0, w_addr=0, w_data=0; pointer starts at 0 after release.
- Single requester: req=4'b0100, addr 20, data 100 -> ack=4'b0100 immediately; next cycle wr_en=1, w_addr=20, w_data=100; reg_file reads 100 at address 20 afterwards.
- Round robin: req=4'b1111 held for 8 cycles with addr i+1, data 10*(i+1) -> ack sequence 0,1,2,3,0,1,2,3; wr_en continuously 1; w_addr 1,2,3,4,1,2,3,4.
- Pointer skip: pointer=2 with req=4'b0011 -> grant requester 0, then requester 1; pointer ends at 2.
- hold: req=4'b0010 with hold=1 for 3 cycles -> ack=0 and wr_en=0 throughout; hold=0 -> ack=4'b0010 in that cycle, write one cycle later.
- Address 0 write with data 10, with and without REG_FILE_ZERO_PROTECT_EN -> reg 0 reads 0 (defined) or 10 (undefined); ack asserted in both builds.
